fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the bare PC register plus single IF/ID register pair with a PC generator, an in-flight request tracker and a DEPTH-entry first-word-fall-through instruction queue. It drives the synchronous instruction ROM and presents a valid/ready stream of (pc, inst) pairs to decode. Decode can stall without losing fetched words, and a redirect from execute flushes the front end in one cycle.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep ROM request tracker and a
// DEPTH-entry FWFT queue feeding decode. Optional macro: FETCH_QUEUE_ADEF_EN.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_W-1:0]          inst_i,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic                       rom_ce_o,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic                       id_excp_o,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pend_pc_q;
  logic              pend_q, run_q;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  wr_idx, rd_idx;
  logic              empty, head_vis, pop, push, issue;
  logic [CNT_W:0]    need;
  logic [ADDR_W-1:0] tgt, push_pc;
  logic [INST_W-1:0] push_inst;
  logic              mis, adef_q, halt_q;

  assign wr_idx   = wr_ptr[PTR_W-1:0];
  assign rd_idx   = rd_ptr[PTR_W-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign head_vis = ~rst & ~empty;

  assign id_valid_o = head_vis & ~redirect_i;
  assign id_pc_o    = head_vis ? pc_mem[rd_idx]   : '0;
  assign id_inst_o  = head_vis ? inst_mem[rd_idx] : '0;
  assign pop        = id_valid_o & id_ready_i;
  assign count_o    = rst ? '0 : count_q;

  // Credit check counts the in-flight word so a response can never hit a full queue.
  assign need  = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q} - {{CNT_W{1'b0}}, pop};
  assign issue = run_q & ~rst & ~redirect_i & (need < (CNT_W+1)'(DEPTH));

  assign rom_ce_o    = issue;
  assign inst_addr_o = pc_q;

  assign push      = ~rst & ~redirect_i & (pend_q | adef_q);
  assign push_pc   = adef_q ? pc_q : pend_pc_q;
  assign push_inst = adef_q ? '0   : inst_i;

`ifdef FETCH_QUEUE_ADEF_EN
  logic [DEPTH-1:0] excp_mem;

  assign mis       = |redirect_pc_i[1:0];
  assign tgt       = redirect_pc_i;
  assign id_excp_o = head_vis & excp_mem[rd_idx];

  // A misaligned target injects one flagged entry, then fetch stays parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      adef_q <= 1'b0;
      halt_q <= 1'b0;
    end else if (redirect_i) begin
      adef_q <= mis;
      halt_q <= mis;
    end else begin
      adef_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) excp_mem[wr_idx] <= adef_q;
  end
`else
  assign mis       = 1'b0;
  assign adef_q    = 1'b0;
  assign halt_q    = 1'b0;
  assign tgt       = redirect_pc_i & ~ADDR_W'(3);
  assign id_excp_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx]   <= push_pc;
      inst_mem[wr_idx] <= push_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      run_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
    end else if (redirect_i) begin
      // Flush: drop queue contents and whatever response is due next cycle.
      pc_q    <= tgt;
      pend_q  <= 1'b0;
      rd_ptr  <= wr_ptr;
      count_q <= '0;
      run_q   <= ~mis;
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_pc_q <= pc_q;
        pc_q      <= pc_q + ADDR_W'(4);
      end
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      count_q <= count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      run_q   <= ~halt_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand sequences for
// mid-operation reset, sustained streaming and PC wrap-around.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        ready, redir;
  logic [31:0] rpc;

  logic [31:0] inst, addr, pc, id_inst;
  logic        ce, vld, excp;
  logic [2:0]  cnt;

  logic [31:0] w_inst, w_addr, w_pc, w_id_inst, w_rpc;
  logic        w_ce, w_vld, w_excp, w_redir, w_ready;
  logic [2:0]  w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  // Synchronous ROM models, one per instance; garbage when not enabled.
  always @(posedge clk) inst   <= ce   ? f(addr)   : 32'hdead_beef;
  always @(posedge clk) w_inst <= w_ce ? f(w_addr) : 32'hdead_beef;

  fetch_queue u_dut (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_o(addr), .rom_ce_o(ce),
    .id_valid_o(vld), .id_ready_i(ready), .id_pc_o(pc), .id_inst_o(id_inst),
    .id_excp_o(excp), .redirect_i(redir), .redirect_pc_i(rpc), .count_o(cnt)
  );

  fetch_queue #(.RESET_PC(32'hffff_fff8)) u_wrap (
    .clk(clk), .rst(rst_w), .inst_i(w_inst), .inst_addr_o(w_addr), .rom_ce_o(w_ce),
    .id_valid_o(w_vld), .id_ready_i(w_ready), .id_pc_o(w_pc), .id_inst_o(w_id_inst),
    .id_excp_o(w_excp), .redirect_i(w_redir), .redirect_pc_i(w_rpc), .count_o(w_cnt)
  );

  typedef struct {
    logic        r, rdy, rd;
    logic [31:0] rpc;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_inst;
    logic        e_ex;
    int          e_cnt;
  } vec_t;

  vec_t tv[0:39];
  int   n = 0;

  task automatic add(input logic r, rdy, rd, input logic [31:0] rp, input logic ce_e,
                     input logic [31:0] ad, input logic v, input logic [31:0] p,
                     input logic ex, input int c);
    tv[n].r = r; tv[n].rdy = rdy; tv[n].rd = rd; tv[n].rpc = rp;
    tv[n].e_ce = ce_e; tv[n].e_addr = ad; tv[n].e_vld = v; tv[n].e_pc = p;
    tv[n].e_inst = (!v || ex) ? 32'h0 : f(p);
    tv[n].e_ex = ex; tv[n].e_cnt = c;
    n++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] A(input int k);
    return 32'h1c00_0000 + 32'(4 * k);
  endfunction

  localparam logic [31:0] T = 32'h1c00_0100;

  initial begin
    rst = 1'b1; rst_w = 1'b1; ready = 1'b0; redir = 1'b0; rpc = '0;
    w_ready = 1'b1; w_redir = 1'b0; w_rpc = '0;

    //   r rdy rd rpc            ce addr       v pc         ex cnt
    add(1, 0, 0, 0,             0, A(0),      0, 0,        0, 0);
    add(0, 1, 0, 0,             0, A(0),      0, 0,        0, 0);
    add(0, 1, 0, 0,             1, A(0),      0, 0,        0, 0);
    add(0, 1, 0, 0,             1, A(1),      0, 0,        0, 0);
    add(0, 1, 0, 0,             1, A(2),      1, A(0),     0, 1);
    add(0, 1, 0, 0,             1, A(3),      1, A(1),     0, 1);
    add(0, 0, 0, 0,             1, A(4),      1, A(2),     0, 1);
    add(0, 0, 0, 0,             1, A(5),      1, A(2),     0, 2);
    add(0, 0, 0, 0,             0, A(6),      1, A(2),     0, 3);
    add(0, 0, 0, 0,             0, A(6),      1, A(2),     0, 4);
    add(0, 0, 0, 0,             0, A(6),      1, A(2),     0, 4);
    add(0, 1, 0, 0,             1, A(6),      1, A(2),     0, 4);
    add(0, 1, 0, 0,             1, A(7),      1, A(3),     0, 3);
    add(0, 1, 0, 0,             1, A(8),      1, A(4),     0, 3);
    add(0, 1, 0, 0,             1, A(9),      1, A(5),     0, 3);
    add(0, 1, 1, T,             0, A(10),     0, 0,        0, 3);
    add(0, 1, 0, 0,             1, T,         0, 0,        0, 0);
    add(0, 1, 0, 0,             1, T+4,       0, 0,        0, 0);
    add(0, 1, 0, 0,             1, T+8,       1, T,        0, 1);
    add(0, 1, 0, 0,             1, T+12,      1, T+4,      0, 1);
    add(0, 1, 1, 32'h1c000202,  0, T+16,      0, 0,        0, 1);
`ifdef FETCH_QUEUE_ADEF_EN
    add(0, 1, 0, 0,             0, 32'h1c000202, 0, 0,     0, 0);
    add(0, 1, 0, 0,             0, 32'h1c000202, 1, 32'h1c000202, 1, 1);
    add(0, 1, 0, 0,             0, 32'h1c000202, 0, 0,     0, 0);
    add(0, 1, 1, 32'h1c000300,  0, 32'h1c000202, 0, 0,     0, 0);
`else
    add(0, 1, 0, 0,             1, 32'h1c000200, 0, 0,     0, 0);
    add(0, 1, 0, 0,             1, 32'h1c000204, 0, 0,     0, 0);
    add(0, 1, 0, 0,             1, 32'h1c000208, 1, 32'h1c000200, 0, 1);
    add(0, 1, 1, 32'h1c000300,  0, 32'h1c00020c, 0, 0,     0, 1);
`endif
    add(0, 1, 0, 0,             1, 32'h1c000300, 0, 0,     0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      rst = tv[i].r; ready = tv[i].rdy; redir = tv[i].rd; rpc = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d rom_ce", i), 32'(ce), 32'(tv[i].e_ce));
      chk($sformatf("row%0d addr", i), addr, tv[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(vld), 32'(tv[i].e_vld));
      chk($sformatf("row%0d excp", i), 32'(excp), 32'(tv[i].e_ex));
      chk($sformatf("row%0d count", i), 32'(cnt), 32'(tv[i].e_cnt));
      if (tv[i].e_vld || tv[i].e_cnt == 0) begin
        chk($sformatf("row%0d pc", i), pc, tv[i].e_pc);
        chk($sformatf("row%0d inst", i), id_inst, tv[i].e_inst);
      end
      @(posedge clk);
      #1;
    end
    redir = 1'b0; ready = 1'b1;

    // Mid-operation reset with a word queued and one in flight.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ce", 32'(ce), 0);
    chk("midrst valid", 32'(vld), 0);
    chk("midrst count", 32'(cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst ce", 32'(ce), 0);
    chk("post rst valid", 32'(vld), 0);
    chk("post rst addr", addr, A(0));
    @(negedge clk);
    chk("first issue ce", 32'(ce), 1);
    chk("first issue addr", addr, A(0));

    // Sustained streaming: one new head per cycle, no bubbles.
    begin
      int k = 0;
      while (!vld && k < 8) begin
        @(negedge clk);
        k++;
      end
      chk("stream start", 32'(vld), 1);
      for (int j = 0; j < 20; j++) begin
        chk($sformatf("stream%0d valid", j), 32'(vld), 1);
        chk($sformatf("stream%0d pc", j), pc, A(j));
        chk($sformatf("stream%0d inst", j), id_inst, f(A(j)));
        @(negedge clk);
      end
    end

    // PC wrap-around on the second instance.
    @(posedge clk);
    #1;
    rst_w = 1'b0;
    begin
      int k = 0;
      @(negedge clk);
      while (!w_vld && k < 8) begin
        @(negedge clk);
        k++;
      end
      chk("wrap start", 32'(w_vld), 1);
      chk("wrap pc0", w_pc, 32'hffff_fff8);
      chk("wrap inst0", w_id_inst, f(32'hffff_fff8));
      @(negedge clk);
      chk("wrap pc1", w_pc, 32'hffff_fffc);
      @(negedge clk);
      chk("wrap pc2", w_pc, 32'h0000_0000);
      chk("wrap inst2", w_id_inst, f(32'h0000_0000));
      chk("wrap excp", 32'(w_excp), 0);
      chk("wrap valid2", 32'(w_vld), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
